aes_decrypt_core: RTL and testbench



---
 rtl/aes_decrypt_core.sv | 257 +++++++++++++++++++++++++
 tb/tb_aes_decrypt_core.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_core.sv
// AES-128 inverse cipher, iterative: one decryption round per clock.
// The 11 round keys are expanded on chip and held until a new key arrives.
// A forward S-box column serves the key schedule. A separate bank of
// inverse S-boxes serves the round datapath.

package aes_gf_pkg;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int k = 0; k < 8; k++) begin
      acc = acc ^ (b[k] ? p : 8'h00);
      p   = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h01;
    p   = a;
    for (int k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc;
  endfunction

  // InvMixColumns on one 32-bit column (row 0 in the top byte).
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage

// Forward S-box: affine transform of the field inverse.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] w_inv;
  assign w_inv  = aes_gf_pkg::gf_inv(i_byte);
  assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform, then the field inverse.
module aes_inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] w_aff;
  assign w_aff  = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]}
                ^ {i_byte[1:0], i_byte[7:2]} ^ 8'h05;
  assign o_byte = aes_gf_pkg::gf_inv(w_aff);
endmodule

module aes_decrypt_core #(
  parameter int KEY_LEN       = 128,
  parameter int DATA_LEN      = 128,
  parameter int NUMS_OF_ROUND = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid_in,
  input  logic [KEY_LEN-1:0]  cipher_key,
  input  logic                data_valid_in,
  input  logic [DATA_LEN-1:0] cipher_text,
  output logic                busy,
  output logic                key_ready,
  output logic                data_valid_out,
  output logic [DATA_LEN-1:0] plain_text
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] KEYEXP = 2'd1;
  localparam logic [1:0] LOAD   = 2'd2;
  localparam logic [1:0] DEC    = 2'd3;
  localparam logic [3:0] LAST_RK = 4'(NUMS_OF_ROUND);

  logic [1:0]          r_state;
  logic [3:0]          r_i;
  logic [3:0]          r_r;
  logic                r_busy;
  logic                r_key_ready;
  logic                r_dv;
  logic                r_pend;
  logic [DATA_LEN-1:0] r_pend_ct;
  logic [DATA_LEN-1:0] r_st;
  logic [DATA_LEN-1:0] r_pt;
  logic [KEY_LEN-1:0]  r_rk [0:NUMS_OF_ROUND];

  logic [127:0] w_rk_prev;
  logic [127:0] w_rk_next;
  logic [127:0] w_rk_cur;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_temp;
  logic [7:0]   w_rcon;
  logic [7:0]   w_sr [0:15];
  logic [7:0]   w_sb [0:15];
  logic [127:0] w_ark;
  logic [127:0] w_imc;
  logic [127:0] w_round;

  // ---------------- key schedule ----------------
  assign w_rk_prev = r_rk[r_i - 4'd1];
  assign w_rot     = {w_rk_prev[23:0], w_rk_prev[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (.i_byte(w_rot[31-8*g -: 8]), .o_byte(w_sub[31-8*g -: 8]));
  end

  // Round constant for the round key being produced (index r_i).
  always_comb begin
    case (r_i)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_temp                = w_sub ^ {w_rcon, 24'h000000};
  assign w_rk_next[127:96]     = w_rk_prev[127:96] ^ w_temp;
  assign w_rk_next[95:64]      = w_rk_prev[95:64]  ^ w_rk_next[127:96];
  assign w_rk_next[63:32]      = w_rk_prev[63:32]  ^ w_rk_next[95:64];
  assign w_rk_next[31:0]       = w_rk_prev[31:0]   ^ w_rk_next[63:32];

  // Round-key storage: deliberately outside reset so a reset does not wipe it.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && key_valid_in) begin
      r_rk[0] <= cipher_key;
    end else if (r_state == KEYEXP) begin
      r_rk[r_i] <= w_rk_next;
    end
  end

  // ---------------- decryption round ----------------
  assign w_rk_cur = r_rk[r_r];

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // InvShiftRows moves row r right by r columns.
      localparam int SRC = 4 * ((c - r + 4) % 4) + r;
      localparam int DST = 4 * c + r;
      assign w_sr[DST] = r_st[127-8*SRC -: 8];
      aes_inv_sbox u_isbox (.i_byte(w_sr[DST]), .o_byte(w_sb[DST]));
      assign w_ark[127-8*DST -: 8] = w_sb[DST] ^ w_rk_cur[127-8*DST -: 8];
    end
    assign w_imc[127-32*c -: 32] = aes_gf_pkg::inv_mix_col(w_ark[127-32*c -: 32]);
  end

  assign w_round = (r_r == 4'd0) ? w_ark : w_imc;

  // ---------------- control ----------------
  // Sequencer: accepts key/data, walks the key schedule and the ten rounds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_i         <= 4'd0;
      r_r         <= 4'd0;
      r_busy      <= 1'b0;
      r_key_ready <= 1'b0;
      r_dv        <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_ct   <= {DATA_LEN{1'b0}};
      r_st        <= {DATA_LEN{1'b0}};
      r_pt        <= {DATA_LEN{1'b0}};
    end else begin
      r_dv <= 1'b0;
      case (r_state)
        IDLE: begin
          if (key_valid_in) begin
            // A key wins the edge; simultaneous data waits in the single pend slot.
            r_key_ready <= 1'b0;
            r_i         <= 4'd1;
            r_pend      <= data_valid_in;
            if (data_valid_in) begin
              r_pend_ct <= cipher_text;
            end
            r_state <= KEYEXP;
            r_busy  <= 1'b1;
          end else if (data_valid_in && r_key_ready) begin
            r_st    <= cipher_text ^ r_rk[NUMS_OF_ROUND];
            r_r     <= LAST_RK - 4'd1;
            r_state <= DEC;
            r_busy  <= 1'b1;
          end
        end
        KEYEXP: begin
          r_i <= r_i + 4'd1;
          if (r_i == LAST_RK) begin
            r_key_ready <= 1'b1;
            if (r_pend) begin
              r_state <= LOAD;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        LOAD: begin
          r_st    <= r_pend_ct ^ r_rk[NUMS_OF_ROUND];
          r_pend  <= 1'b0;
          r_r     <= LAST_RK - 4'd1;
          r_state <= DEC;
        end
        DEC: begin
          r_st <= w_round;
          r_r  <= r_r - 4'd1;
          if (r_r == 4'd0) begin
            r_pt    <= w_round;
            r_dv    <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign key_ready      = r_key_ready;
  assign data_valid_out = r_dv;
  assign plain_text     = r_pt;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Testbench for aes_decrypt_core: FIPS-197 known answers, protocol corner
// cases and random traffic checked by a scoreboard fed from a byte-level
// reference model of the inverse cipher.

module tb_aes_decrypt_core;

  logic         clk;
  logic         reset;
  logic         key_valid_in;
  logic [127:0] cipher_key;
  logic         data_valid_in;
  logic [127:0] cipher_text;
  logic         busy;
  logic         key_ready;
  logic         data_valid_out;
  logic [127:0] plain_text;

  aes_decrypt_core #(.KEY_LEN(128), .DATA_LEN(128), .NUMS_OF_ROUND(10)) dut (
    .clk(clk), .reset(reset),
    .key_valid_in(key_valid_in), .cipher_key(cipher_key),
    .data_valid_in(data_valid_in), .cipher_text(cipher_text),
    .busy(busy), .key_ready(key_ready),
    .data_valid_out(data_valid_out), .plain_text(plain_text)
  );

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] pt;
    int           due;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;
  logic [7:0]   sb  [0:255];
  logic [7:0]   isb [0:255];
  // transaction-level model of the DUT's acceptance rules
  int           m_free = 0;
  logic         m_key_ok = 1'b0;
  logic [127:0] m_key = 128'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] m9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction
  function automatic logic [7:0] m11(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction
  function automatic logic [7:0] m13(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction
  function automatic logic [7:0] m14(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  // S-box from the generator-3 walk, inverse table by inverting it.
  task automatic build_tables();
    logic [7:0] p, qq, x;
    p  = 8'h01;
    qq = 8'h01;
    do begin
      p  = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      qq = qq ^ (qq << 1);
      qq = qq ^ (qq << 2);
      qq = qq ^ (qq << 4);
      if (qq[7]) qq = qq ^ 8'h09;
      x = qq ^ {qq[6:0], qq[7]} ^ {qq[5:0], qq[7:6]} ^ {qq[4:0], qq[7:5]} ^ {qq[3:0], qq[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w [0:43];
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ w[40 + k/4][31-8*(k%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*((c+r)%4)+r] = isb[s[4*c+r]];
      for (int k = 0; k < 16; k++) t[k] = t[k] ^ w[4*rnd + k/4][31-8*(k%4) -: 8];
      if (rnd != 0) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c+0] = m14(t[4*c]) ^ m11(t[4*c+1]) ^ m13(t[4*c+2]) ^ m9(t[4*c+3]);
          s[4*c+1] = m9(t[4*c])  ^ m14(t[4*c+1]) ^ m11(t[4*c+2]) ^ m13(t[4*c+3]);
          s[4*c+2] = m13(t[4*c]) ^ m9(t[4*c+1])  ^ m14(t[4*c+2]) ^ m11(t[4*c+3]);
          s[4*c+3] = m11(t[4*c]) ^ m13(t[4*c+1]) ^ m9(t[4*c+2])  ^ m14(t[4*c+3]);
        end
      end else begin
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // Decide what the DUT does with a pulse at edge a and queue the response.
  task automatic model_accept(input int a, input logic kv, input logic [127:0] key,
                              input logic dv, input logic [127:0] ct);
    exp_t x;
    if (a >= m_free) begin
      if (kv) begin
        m_key    = key;
        m_key_ok = 1'b1;
        if (dv) begin
          x.pt = ref_decrypt(key, ct); x.due = a + 21; q.push_back(x);
          m_free = a + 22;
        end else begin
          m_free = a + 11;
        end
      end else if (dv && m_key_ok) begin
        x.pt = ref_decrypt(m_key, ct); x.due = a + 10; q.push_back(x);
        m_free = a + 11;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic kv, input logic [127:0] key, input logic dv, input logic [127:0] ct);
    key_valid_in  = kv;
    cipher_key    = key;
    data_valid_in = dv;
    cipher_text   = ct;
    tick(1);
    key_valid_in  = 1'b0;
    data_valid_in = 1'b0;
    model_accept(cyc, kv, key, dv, ct);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_drain(input int limit, input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    tick(1);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d responses still pending after %0d cycles, expected 0", name, q.size(), limit);
      q.delete();
    end
  endtask

  task automatic wait_idle();
    while (cyc + 1 < m_free) tick(1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    q.delete();
    m_key_ok = 1'b0;
    m_free   = 0;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && data_valid_out) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL dv_unexpected: data_valid_out=1 at edge %0d with pt %h, expected no output", cyc, plain_text);
      end else begin
        e = q.pop_front();
        if (plain_text !== e.pt || cyc != e.due) begin
          n_err++;
          $display("FAIL dv_result: got pt %h at edge %0d, expected pt %h at edge %0d", plain_text, cyc, e.pt, e.due);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic         kv, dv;
    logic [127:0] rk, rc;
    int           gap;
    build_tables();
    reset = 1'b1; key_valid_in = 1'b0; data_valid_in = 1'b0;
    cipher_key = 128'h0; cipher_text = 128'h0;
    apply_reset();
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_key_ready", {127'h0, key_ready}, 128'h0);
    check("rst_dv", {127'h0, data_valid_out}, 128'h0);
    check("rst_pt", plain_text, 128'h0);

    // key and ciphertext on the same pulse
    send(1'b1, KEY1, 1'b1, CT1);
    check("s1_busy", {127'h0, busy}, 128'h1);
    wait_drain(40, "s1_drain");
    check("s1_pt_kat", plain_text, PT1);

    // repeated data while busy is dropped; back-to-back after T10 accepted
    wait_idle();
    send(1'b0, 128'h0, 1'b1, CT1);
    tick(2);
    send(1'b0, 128'h0, 1'b1, 128'hdeadbeef_00000000_11111111_22222222);
    wait_drain(40, "s3_drop");
    wait_idle();
    send(1'b0, 128'h0, 1'b1, CT1);
    tick(10);
    send(1'b0, 128'h0, 1'b1, CT1 ^ 128'h1);
    wait_drain(40, "s3_b2b");

    // key alone, then data under the new key
    wait_idle();
    send(1'b1, KEY2, 1'b0, 128'h0);
    tick(9);
    check("s2_key_ready_k9", {127'h0, key_ready}, 128'h0);
    tick(1);
    check("s2_key_ready_k10", {127'h0, key_ready}, 128'h1);
    check("s2_busy_k10", {127'h0, busy}, 128'h0);
    check("s2_rk10", dut.r_rk[10], RK10);
    send(1'b0, 128'h0, 1'b1, CT2);
    wait_drain(30, "s2_drain");
    check("s2_pt_kat", plain_text, PT2);

    // no key after reset: data is dropped
    apply_reset();
    send(1'b0, 128'h0, 1'b1, CT1);
    for (int i = 0; i < 40; i++) begin
      check("s4_busy", {127'h0, busy}, 128'h0);
      tick(1);
    end
    check("s4_key_ready", {127'h0, key_ready}, 128'h0);

    // reset in the middle of a decryption
    send(1'b1, KEY1, 1'b1, CT1);
    wait_drain(40, "s5_pre");
    wait_idle();
    send(1'b0, 128'h0, 1'b1, CT2);
    tick(4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    m_key_ok = 1'b0;
    m_free   = 0;
    #1;
    check("s5_dv", {127'h0, data_valid_out}, 128'h0);
    check("s5_pt", plain_text, 128'h0);
    check("s5_busy", {127'h0, busy}, 128'h0);
    check("s5_key_ready", {127'h0, key_ready}, 128'h0);
    tick(2);
    reset = 1'b0;
    tick(1);
    send(1'b1, KEY1, 1'b1, CT1);
    wait_drain(40, "s5_after");
    check("s5_pt_kat", plain_text, PT1);

    // random traffic, including pulses that land while busy
    for (int it = 0; it < 40; it++) begin
      kv  = ($urandom_range(0, 3) == 0);
      dv  = ($urandom_range(0, 3) != 0);
      rk  = {$urandom, $urandom, $urandom, $urandom};
      rc  = {$urandom, $urandom, $urandom, $urandom};
      gap = $urandom_range(0, 24);
      send(kv, rk, dv, rc);
      tick(gap);
    end
    wait_drain(60, "rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
